// File: rtl/fp_to_int.sv
// Float-to-signed-integer converter: two-stage valid/ready pipeline with
// round-to-nearest-even and saturation. The float_t format lives in float_pkg.
package float_pkg;
  localparam int MantissaWidth       = 23;
  localparam int BiasedExponentWidth = 8;

  typedef struct packed {
    logic                           sign;
    logic [BiasedExponentWidth-1:0] biased_exponent;
    logic [MantissaWidth-1:0]       mantissa;
  } float_t;
endpackage

module fp_to_int
  import float_pkg::*;
#(
  parameter int IntWidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  output logic                op_ready_o,
  input  logic                op_valid_i,
  input  float_t              op_i,
  input  logic                int_ready_i,
  output logic                int_valid_o,
  output logic [IntWidth-1:0] int_data_o,
  output logic                overflow_o
);

  localparam int MW    = MantissaWidth;
  localparam int EW    = BiasedExponentWidth;
  localparam int FracW = MW + 1;
  localparam int WideW = MW + 1 + IntWidth;
  localparam int ShW   = $clog2(IntWidth + 1);

  localparam logic signed [EW:0] Bias   = (EW+1)'((2 ** (EW - 1)) - 1);
  localparam logic [IntWidth:0]  PosMax = {2'b00, {(IntWidth-1){1'b1}}};
  localparam logic [IntWidth:0]  NegMax = {2'b01, {(IntWidth-1){1'b0}}};
  localparam logic [IntWidth-1:0] IntMax = {1'b0, {(IntWidth-1){1'b1}}};
  localparam logic [IntWidth-1:0] IntMin = {1'b1, {(IntWidth-1){1'b0}}};

  // ---------------------------------------------------------------- handshake
  logic s1_valid_q, s2_valid_q;
  logic s2_load, accept;

  assign s2_load    = !s2_valid_q || int_ready_i;
  assign op_ready_o = !s1_valid_q || s2_load;
  assign accept     = op_valid_i && op_ready_o;

  // ------------------------------------------------------ S1: classification
  logic                 s1_sign_q,    s1_sign_d;
  logic                 s1_zero_q,    s1_zero_d;
  logic                 s1_special_q, s1_special_d;
  logic signed [EW:0]   s1_exp_q,     s1_exp_d;
  logic [MW:0]          s1_sig_q,     s1_sig_d;

  always_comb begin
    s1_sign_d    = op_i.sign;
    s1_zero_d    = (op_i.biased_exponent == '0);
    s1_special_d = &op_i.biased_exponent;
    s1_exp_d     = $signed({1'b0, op_i.biased_exponent}) - Bias;
    s1_sig_d     = {1'b1, op_i.mantissa};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, whatever the statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_zero_q    <= 1'b0;
      s1_special_q <= 1'b0;
      s1_exp_q     <= '0;
      s1_sig_q     <= '0;
    end else begin
      if (op_ready_o) s1_valid_q <= op_valid_i;
      if (accept) begin
        s1_sign_q    <= s1_sign_d;
        s1_zero_q    <= s1_zero_d;
        s1_special_q <= s1_special_d;
        s1_exp_q     <= s1_exp_d;
        s1_sig_q     <= s1_sig_d;
      end
    end
  end

  // ------------------------------------------- S2: shift, round, saturate
  // Fixed point with FracW fraction bits: value * 2^FracW = sig << (e + 1),
  // valid for -1 <= e < IntWidth; everything else is resolved by class.
  logic [ShW-1:0]      sh_amt;
  logic [WideW-1:0]    wide;
  logic [IntWidth-1:0] int_part;
  logic                guard, round_bit, sticky, inc;
  logic [IntWidth:0]   mag;
  logic                is_nan, e_small, e_big;
  logic [IntWidth-1:0] res_d, int_data_q;
  logic                ovf_d, overflow_q;

  always_comb begin
    sh_amt    = ShW'(s1_exp_q + 1);
    wide      = {{IntWidth{1'b0}}, s1_sig_q} << sh_amt;
    int_part  = wide[WideW-1 -: IntWidth];
    guard     = wide[FracW-1];
    round_bit = wide[FracW-2];
    sticky    = |wide[FracW-3:0];
    inc       = guard && (round_bit || sticky || int_part[0]);
    mag       = {1'b0, int_part} + (IntWidth+1)'(inc);
    is_nan    = |s1_sig_q[MW-1:0];
    e_small   = (s1_exp_q < -1);
    e_big     = (s1_exp_q >= IntWidth);

    res_d = '0;
    ovf_d = 1'b0;
    if (s1_zero_q || (e_small && !s1_special_q)) begin
      res_d = '0;
    end else if (s1_special_q && is_nan) begin
      ovf_d = 1'b1;
    end else if (s1_special_q || e_big
                 || (!s1_sign_q && (mag > PosMax))
                 || ( s1_sign_q && (mag > NegMax))) begin
      res_d = s1_sign_q ? IntMin : IntMax;
      ovf_d = 1'b1;
    end else begin
      // Negating 2^(IntWidth-1) wraps to itself, which is the exact answer.
      res_d = s1_sign_q ? -mag[IntWidth-1:0] : mag[IntWidth-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid_q <= 1'b0;
      int_data_q <= '0;
      overflow_q <= 1'b0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      // NOTE: data loads only alongside a valid bubble-free transfer, so the
      // outputs hold their last value when idle and stay stable while stalled.
      if (s1_valid_q) begin
        int_data_q <= res_d;
        overflow_q <= ovf_d;
      end
    end
  end

  assign int_valid_o = s2_valid_q;
  assign int_data_o  = int_data_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_fp_to_int.sv
// Directed self-checking bench for fp_to_int (32-bit result, single precision).
module tb_fp_to_int;
  import float_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        op_ready_o;
  logic        op_valid_i;
  float_t      op_i;
  logic        int_ready_i;
  logic        int_valid_o;
  logic [31:0] int_data_o;
  logic        overflow_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] vin  [16];
  logic [31:0] vexp [16];
  logic        vovf [16];

  always #5 clk_i = ~clk_i;

  fp_to_int #(.IntWidth(32)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .op_ready_o  (op_ready_o),
    .op_valid_i  (op_valid_i),
    .op_i        (op_i),
    .int_ready_i (int_ready_i),
    .int_valid_o (int_valid_o),
    .int_data_o  (int_data_o),
    .overflow_o  (overflow_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [31:0] in, input logic [31:0] exp,
                         input logic ovf);
    vin[i]  = in;
    vexp[i] = exp;
    vovf[i] = ovf;
  endtask

  // Back-to-back stream with the consumer always ready: result i must be
  // valid at the second edge after its accept edge.
  task automatic stream(input string tag, input int n);
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk_i);
      op_valid_i = (i < n);
      op_i       = (i < n) ? float_t'(vin[i]) : '0;
      #1;
      check($sformatf("%s ready %0d", tag, i), 32'(op_ready_o), 32'd1);
      if (i < 2) begin
        check($sformatf("%s early valid %0d", tag, i), 32'(int_valid_o), 32'd0);
      end else begin
        check($sformatf("%s valid %0d", tag, i - 2), 32'(int_valid_o), 32'd1);
        check($sformatf("%s data %0d", tag, i - 2), int_data_o, vexp[i-2]);
        check($sformatf("%s ovf %0d", tag, i - 2), 32'(overflow_o), 32'(vovf[i-2]));
      end
    end
  endtask

  initial begin
    int          sent, recv, cyc;
    logic        stall_prev, acc, drn, exp_rdy;
    logic [31:0] held;

    rst_ni      = 1'b0;
    op_valid_i  = 1'b0;
    op_i        = '0;
    int_ready_i = 1'b1;
    #1;
    check("reset valid", 32'(int_valid_o), 32'd0);
    check("reset data", int_data_o, 32'd0);
    check("reset ovf", 32'(overflow_o), 32'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check("post-reset ready", 32'(op_ready_o), 32'd1);

    // Rounding: ties to even, halves below one, just-below-half.
    set_vec(0, 32'h40200000, 32'd2,          1'b0);
    set_vec(1, 32'h40600000, 32'd4,          1'b0);
    set_vec(2, 32'hBFC00000, 32'hFFFFFFFE,   1'b0);
    set_vec(3, 32'h3F000000, 32'd0,          1'b0);
    set_vec(4, 32'h3F400000, 32'd1,          1'b0);
    set_vec(5, 32'h3FC00000, 32'd2,          1'b0);
    set_vec(6, 32'hBF000000, 32'd0,          1'b0);
    set_vec(7, 32'h3EFFFFFF, 32'd0,          1'b0);
    stream("round", 8);

    // Saturation, specials and the exact most-negative value.
    set_vec(0, 32'h501502F9, 32'h7FFFFFFF, 1'b1);
    set_vec(1, 32'hCF000000, 32'h80000000, 1'b0);
    set_vec(2, 32'hCF000001, 32'h80000000, 1'b1);
    set_vec(3, 32'h7F800000, 32'h7FFFFFFF, 1'b1);
    set_vec(4, 32'h7FC00000, 32'h00000000, 1'b1);
    set_vec(5, 32'hFF800000, 32'h80000000, 1'b1);
    set_vec(6, 32'h4F000000, 32'h7FFFFFFF, 1'b1);
    set_vec(7, 32'h4EFFFFFF, 32'h7FFFFF80, 1'b0);
    stream("sat", 8);

    // Zero, negative zero, denormal.
    set_vec(0, 32'h00000000, 32'd0, 1'b0);
    set_vec(1, 32'h80000000, 32'd0, 1'b0);
    set_vec(2, 32'h00000123, 32'd0, 1'b0);
    stream("zero", 3);

    // Backpressure: 1.0 .. 8.0 with a randomly stalling consumer.
    set_vec(0, 32'h3F800000, 32'd1, 1'b0);
    set_vec(1, 32'h40000000, 32'd2, 1'b0);
    set_vec(2, 32'h40400000, 32'd3, 1'b0);
    set_vec(3, 32'h40800000, 32'd4, 1'b0);
    set_vec(4, 32'h40A00000, 32'd5, 1'b0);
    set_vec(5, 32'h40C00000, 32'd6, 1'b0);
    set_vec(6, 32'h40E00000, 32'd7, 1'b0);
    set_vec(7, 32'h41000000, 32'd8, 1'b0);
    sent = 0;
    recv = 0;
    cyc  = 0;
    stall_prev = 1'b0;
    held = '0;
    while (recv < 8 && cyc < 300) begin
      @(negedge clk_i);
      int_ready_i = 1'($urandom_range(0, 1));
      op_valid_i  = (sent < 8);
      op_i        = (sent < 8) ? float_t'(vin[sent]) : '0;
      #1;
      exp_rdy = !((sent - recv) == 2 && !int_ready_i);
      check($sformatf("bp ready c%0d", cyc), 32'(op_ready_o), 32'(exp_rdy));
      if (stall_prev) begin
        check($sformatf("bp stall valid c%0d", cyc), 32'(int_valid_o), 32'd1);
        check($sformatf("bp stall data c%0d", cyc), int_data_o, held);
      end
      if (int_valid_o && int_ready_i) begin
        check($sformatf("bp data %0d", recv), int_data_o, vexp[recv]);
        check($sformatf("bp ovf %0d", recv), 32'(overflow_o), 32'd0);
      end
      stall_prev = int_valid_o && !int_ready_i;
      held       = int_data_o;
      acc        = op_valid_i && op_ready_o;
      drn        = int_valid_o && int_ready_i;
      @(posedge clk_i);
      if (acc) sent++;
      if (drn) recv++;
      cyc++;
    end
    check("bp received", 32'(recv), 32'd8);

    // Reset asserted between edges with two operands in flight.
    @(negedge clk_i);
    int_ready_i = 1'b0;
    op_valid_i  = 1'b1;
    op_i        = float_t'(32'h3F800000);
    @(posedge clk_i);
    @(negedge clk_i);
    op_i = float_t'(32'h40000000);
    @(posedge clk_i);
    @(negedge clk_i);
    op_valid_i = 1'b0;
    #1;
    check("rst inflight valid", 32'(int_valid_o), 32'd1);
    check("rst inflight data", int_data_o, 32'd1);
    #1;
    rst_ni = 1'b0;
    #1;
    check("rst async valid", 32'(int_valid_o), 32'd0);
    check("rst async data", int_data_o, 32'd0);
    @(negedge clk_i);
    rst_ni      = 1'b1;
    int_ready_i = 1'b1;
    op_valid_i  = 1'b1;
    op_i        = float_t'(32'h41200000);
    #1;
    check("rst release ready", 32'(op_ready_o), 32'd1);
    check("rst release valid", 32'(int_valid_o), 32'd0);
    @(posedge clk_i);
    #1;
    op_valid_i = 1'b0;
    check("rst lat1 valid", 32'(int_valid_o), 32'd0);
    @(posedge clk_i);
    #1;
    check("rst lat2 valid", 32'(int_valid_o), 32'd1);
    check("rst lat2 data", int_data_o, 32'd10);
    check("rst lat2 ovf", 32'(overflow_o), 32'd0);
    @(posedge clk_i);
    #1;
    check("rst no duplicate", 32'(int_valid_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
